inst_queue_ctrl: RTL and testbench

- Control stage directly upstream of the 64x48 distributed RAM (dist_mem).
- Turns that RAM into a circular FIFO between the fetch stage (producer) and decode (consumer).
- Drives the RAM write port (a, d, we) and read address (dpra); returns its asynchronous read data (dpo) as queue head.
- Also provides valid/ready handshakes, an early almost-full stall for fetch, and a pipeline flush.

---
 rtl/inst_queue_if.sv | 33 +++
 rtl/inst_queue_ctrl.sv | 85 ++++++++
 tb/tb_inst_queue_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Handshake and RAM-port bundle between the instruction queue controller,
// the fetch/decode stages and the 64x48 distributed RAM.
interface inst_queue_if #(
    parameter int AW = 6,
    parameter int DW = 48
);
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          almost_full;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [AW-1:0] mem_dpra;
    logic [DW-1:0] mem_dpo;
    logic [AW:0]   count;

    modport slave (
        input  flush, in_valid, in_data, out_ready, mem_dpo,
        output in_ready, almost_full, out_valid, out_data,
               mem_a, mem_d, mem_we, mem_dpra, count
    );

    modport master (
        output flush, in_valid, in_data, out_ready, mem_dpo,
        input  in_ready, almost_full, out_valid, out_data,
               mem_a, mem_d, mem_we, mem_dpra, count
    );
endinterface

// File: rtl/inst_queue_ctrl.sv
// Circular-FIFO controller wrapping the fetch->decode instruction RAM:
// pointer/occupancy bookkeeping, handshakes, almost-full stall and flush.
module inst_queue_ctrl #(
    parameter int AW        = 6,
    parameter int DW        = 48,
    parameter int AF_THRESH = 60
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  q
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW:0]   FULL_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C     = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(32'd0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(32'd1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [AW:0]   cnt_r, cnt_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;

    // Flow control looks only at the occupancy register, so in_ready never
    // depends on out_ready and no ready-to-ready path exists.
    assign in_ready_s  = (cnt_r != FULL_C);
    assign out_valid_s = (cnt_r != CNT_ZERO);
    assign push_s      = q.in_valid  & in_ready_s  & ~q.flush;
    assign pop_s       = q.out_ready & out_valid_s & ~q.flush;

    assign q.in_ready    = in_ready_s;
    assign q.out_valid   = out_valid_s;
    assign q.almost_full = (cnt_r >= AF_C);
    assign q.count       = cnt_r;
    assign q.mem_a       = wr_ptr_r;
    assign q.mem_d       = q.in_data;
    assign q.mem_we      = push_s;
    assign q.mem_dpra    = rd_ptr_r;
    assign q.out_data    = q.mem_dpo;

    // Next-state: flush wins over any push/pop; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        cnt_s    = cnt_r;
        if (q.flush) begin
            wr_ptr_s = PTR_ZERO;
            rd_ptr_s = PTR_ZERO;
            cnt_s    = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_s = cnt_r + CNT_ONE;
                2'b01:   cnt_s = cnt_r - CNT_ONE;
                default: cnt_s = cnt_r;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            cnt_r    <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            cnt_r    <= cnt_s;
        end
    end
endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Scoreboard bench for inst_queue_ctrl: a queue-based reference model plus a
// RAM model; random traffic followed by the directed boundary scenarios.
module tb_inst_queue_ctrl;
    localparam int AW    = 6;
    localparam int DW    = 48;
    localparam int DEPTH = 64;
    localparam int AF    = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;

    inst_queue_if #(.AW(AW), .DW(DW)) q ();

    inst_queue_ctrl #(.AW(AW), .DW(DW), .AF_THRESH(AF)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q.slave)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (q.mem_we) ram[q.mem_a] <= q.mem_d;
    end
    assign q.mem_dpo = ram[q.mem_dpra];

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [DW-1:0] sb [$];
    int exp_cnt = 0;
    int exp_wr  = 0;
    int exp_rd  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update on each accepted edge; reset clears it asynchronously.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sb.delete();
                exp_cnt = 0; exp_wr = 0; exp_rd = 0;
            end else if (q.flush) begin
                sb.delete();
                exp_cnt = 0; exp_wr = 0; exp_rd = 0;
            end else begin
                if (q.in_valid && exp_cnt < DEPTH) begin
                    sb.push_back(q.in_data);
                    exp_wr = (exp_wr + 1) % DEPTH;
                    exp_cnt = exp_cnt + 1;
                end
                if (q.out_ready && exp_cnt_pre_pop_nonzero()) begin
                    exp_rd = (exp_rd + 1) % DEPTH;
                    exp_cnt = exp_cnt - 1;
                end
            end
        end
    end

    // pop legality is decided on the occupancy seen before this edge's push
    logic pre_nonzero = 1'b0;
    function automatic logic exp_cnt_pre_pop_nonzero();
        return pre_nonzero;
    endfunction

    // Monitor: compares every output mid-cycle and pops the scoreboard on a consume.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                pre_nonzero = (exp_cnt != 0);
                chk("count",       64'(q.count),       64'(exp_cnt));
                chk("out_valid",   64'(q.out_valid),   64'(exp_cnt != 0));
                chk("in_ready",    64'(q.in_ready),    64'(exp_cnt != DEPTH));
                chk("almost_full", 64'(q.almost_full), 64'(exp_cnt >= AF));
                chk("mem_we",      64'(q.mem_we),
                    64'(q.in_valid && exp_cnt != DEPTH && !q.flush));
                chk("mem_a",       64'(q.mem_a),       64'(exp_wr));
                chk("mem_dpra",    64'(q.mem_dpra),    64'(exp_rd));
                if (q.out_valid && q.out_ready && !q.flush) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        chk("out_data", 64'(q.out_data), 64'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic step(input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        q.in_valid  = iv;
        q.in_data   = d;
        q.out_ready = ordy;
        q.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_cnt != 0; i++) step(1'b0, 48'h0, 1'b1, 1'b0);
        chk("drain_empty", 64'(exp_cnt), 64'(0));
        chk("drain_sb",    64'(sb.size()), 64'(0));
    endtask

    initial begin
        q.in_valid = 1'b0; q.in_data = 48'h0; q.out_ready = 1'b0; q.flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready",    64'(q.in_ready),    64'(1));
        chk("rst_out_valid",   64'(q.out_valid),   64'(0));
        chk("rst_count",       64'(q.count),       64'(0));
        chk("rst_almost_full", 64'(q.almost_full), 64'(0));
        chk("rst_mem_we",      64'(q.mem_we),      64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single push/pop
        step(1'b1, 48'h1234_5678_9ABC, 1'b0, 1'b0);
        chk("single_valid", 64'(q.out_valid), 64'(1));
        chk("single_data",  64'(q.out_data),  64'(48'h1234_5678_9ABC));
        chk("single_count", 64'(q.count),     64'(1));
        step(1'b0, 48'h0, 1'b1, 1'b0);
        chk("single_empty", 64'(q.out_valid), 64'(0));

        // fill to full, extra push dropped
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 48'(i), 1'b0, 1'b0);
            if (i == AF - 1) chk("af_at_60", 64'(q.almost_full), 64'(1));
        end
        chk("full_in_ready", 64'(q.in_ready), 64'(0));
        q.in_valid = 1'b1; q.in_data = 48'hDEAD; #1;
        chk("full_no_we", 64'(q.mem_we), 64'(0));
        step(1'b1, 48'hDEAD, 1'b0, 1'b0);
        chk("full_count", 64'(q.count), 64'(64));
        for (int i = 0; i < 10; i++) step(1'b0, 48'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 48'(100 + i), 1'b0, 1'b0);
        // full with push+pop: only the pop happens
        step(1'b1, 48'hBEEF, 1'b1, 1'b0);
        chk("full_pp_count", 64'(q.count),    64'(63));
        chk("full_pp_ready", 64'(q.in_ready), 64'(1));
        drain();

        // count=5 with simultaneous push/pop
        for (int i = 0; i < 5; i++) step(1'b1, 48'(200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 48'(300 + i), 1'b1, 1'b0);
        chk("pp5_count", 64'(q.count), 64'(5));
        drain();

        // flush priority
        for (int i = 0; i < 7; i++) step(1'b1, 48'(400 + i), 1'b0, 1'b0);
        q.in_valid = 1'b1; q.out_ready = 1'b1; q.flush = 1'b1; #1;
        chk("flush_no_we", 64'(q.mem_we), 64'(0));
        step(1'b1, 48'h777, 1'b1, 1'b1);
        step(1'b0, 48'h0, 1'b0, 1'b0);
        chk("flush_count", 64'(q.count),    64'(0));
        chk("flush_a",     64'(q.mem_a),    64'(0));
        chk("flush_dpra",  64'(q.mem_dpra), 64'(0));

        // async reset mid-stream
        for (int i = 0; i < 20; i++) step(1'b1, 48'(500 + i), 1'b0, 1'b0);
        q.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 64'(q.count),     64'(0));
        chk("arst_valid", 64'(q.out_valid), 64'(0));
        chk("arst_we",    64'(q.mem_we),    64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        q.in_valid = 1'b1; q.in_data = 48'hABC; #1;
        chk("arst_first_a", 64'(q.mem_a), 64'(0));
        step(1'b1, 48'hABC, 1'b0, 1'b0);
        drain();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 99) < 65), {16'($urandom), 32'($urandom)},
                 1'($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 30 : 70)),
                 1'($urandom_range(0, 199) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
